// File: rtl/heart_cnt_gen_pkg.sv
// Shared encodings for the heart step-sequence generator and its LED decoder.
package heart_pkg;

  localparam int unsigned HEART_W = 4;
  localparam logic [HEART_W-1:0] HEART_BLANK = 4'd8;

  typedef enum logic [1:0] {
    MODE_UP   = 2'b00,
    MODE_DOWN = 2'b01,
    MODE_PING = 2'b10,
    MODE_HOLD = 2'b11
  } mode_t;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_t;

endpackage

// File: rtl/heart_cnt_gen_tick_div.sv
// Prescaler: one-cycle tick every CLK_DIV enabled clocks, restarting from zero whenever disabled.
module tick_div #(
  parameter int unsigned CLK_DIV = 6_000_000
) (
  input  logic clk_in,
  input  logic rst_n_in,
  input  logic en_in,
  output logic tick
);

  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_cnt;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      div_cnt <= '0;
    end else if (!en_in || div_cnt == DIV_LAST) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  assign tick = en_in && (div_cnt == DIV_LAST);

endmodule

// File: rtl/heart_cnt_gen.sv
// Step-sequence generator driving the 4-bit heart_cnt index of the LED-pattern decoder.
module heart_cnt_gen
  import heart_pkg::*;
#(
  parameter int unsigned CLK_DIV = 6_000_000,
  parameter int unsigned CNT_MAX = 7
) (
  input  logic               clk_in,
  input  logic               rst_n_in,
  input  logic               en_in,
  input  logic [1:0]         mode_in,
  output logic [HEART_W-1:0] heart_cnt,
  output logic               step_pulse
);

  localparam logic [2:0] POS_MAX = 3'(CNT_MAX);

  logic       tick;
  logic [2:0] pos;
  logic [2:0] pos_next;
  dir_t       dir;
  dir_t       dir_next;
  logic       stepped;

  tick_div #(
    .CLK_DIV(CLK_DIV)
  ) u_tick_div (
    .clk_in  (clk_in),
    .rst_n_in(rst_n_in),
    .en_in   (en_in),
    .tick    (tick)
  );

  // Mode is only looked at on a tick; PING turns around without repeating the end value.
  always_comb begin
    pos_next = pos;
    dir_next = dir;
    stepped  = 1'b0;
    if (tick) begin
      case (mode_t'(mode_in))
        MODE_UP: begin
          pos_next = (pos == POS_MAX) ? 3'd0 : pos + 3'd1;
          dir_next = DIR_UP;
          stepped  = 1'b1;
        end
        MODE_DOWN: begin
          pos_next = (pos == 3'd0) ? POS_MAX : pos - 3'd1;
          dir_next = DIR_DOWN;
          stepped  = 1'b1;
        end
        MODE_PING: begin
          stepped = 1'b1;
          if (dir == DIR_UP) begin
            if (pos == POS_MAX) begin
              pos_next = POS_MAX - 3'd1;
              dir_next = DIR_DOWN;
            end else begin
              pos_next = pos + 3'd1;
            end
          end else begin
            if (pos == 3'd0) begin
              pos_next = 3'd1;
              dir_next = DIR_UP;
            end else begin
              pos_next = pos - 3'd1;
            end
          end
        end
        default: begin
          pos_next = pos;
          dir_next = dir;
          stepped  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      pos        <= 3'd0;
      dir        <= DIR_UP;
      heart_cnt  <= '0;
      step_pulse <= 1'b0;
    end else begin
      pos        <= pos_next;
      dir        <= dir_next;
      heart_cnt  <= en_in ? {1'b0, pos_next} : HEART_BLANK;
      step_pulse <= stepped;
    end
  end

endmodule

// File: tb/tb_heart_cnt_gen.sv
// Scoreboard bench for heart_cnt_gen: a per-cycle behavioural model queues expectations, a monitor checks them.
module tb_heart_cnt_gen;

  localparam int CLK_DIV = 4;
  localparam int CNT_MAX = 7;

  logic       clk_in;
  logic       rst_n_in;
  logic       en_in;
  logic [1:0] mode_in;
  logic [3:0] heart_cnt;
  logic       step_pulse;

  typedef struct {
    int hc;
    int sp;
  } exp_t;

  exp_t sb_q[$];

  int check_cnt = 0;
  int pass_cnt  = 0;

  int m_cnt = 0;
  int m_pos = 0;
  int m_dir = 1;

  heart_cnt_gen #(
    .CLK_DIV(CLK_DIV),
    .CNT_MAX(CNT_MAX)
  ) dut (
    .clk_in    (clk_in),
    .rst_n_in  (rst_n_in),
    .en_in     (en_in),
    .mode_in   (mode_in),
    .heart_cnt (heart_cnt),
    .step_pulse(step_pulse)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic checkOutput(input string name, input int act, input int exp);
    check_cnt++;
    if (act == exp) pass_cnt++;
    else $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
  endtask

  task automatic applyStimulus(input logic en, input logic [1:0] mode, input int cycles);
    en_in   = en;
    mode_in = mode;
    repeat (cycles) @(negedge clk_in);
  endtask

  task automatic waitHeart(input int target);
    int n;
    n = 0;
    while (heart_cnt != 4'(target) && n < 100) begin
      @(negedge clk_in);
      n++;
    end
    checkOutput("wait_heart", int'(heart_cnt), target);
  endtask

  // Reference model: index arithmetic straight from the step rules, one entry per clock edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk_in);
      e.sp = 0;
      if (!rst_n_in) begin
        m_cnt = 0; m_pos = 0; m_dir = 1;
        e.hc = 0;
      end else if (!en_in) begin
        m_cnt = 0;
        e.hc = 8;
      end else begin
        if (m_cnt == CLK_DIV - 1) begin
          m_cnt = 0;
          case (mode_in)
            2'b00: begin m_pos = (m_pos + 1) % (CNT_MAX + 1); m_dir = 1; e.sp = 1; end
            2'b01: begin m_pos = (m_pos + CNT_MAX) % (CNT_MAX + 1); m_dir = -1; e.sp = 1; end
            2'b10: begin
              if (m_pos + m_dir < 0 || m_pos + m_dir > CNT_MAX) m_dir = -m_dir;
              m_pos = m_pos + m_dir;
              e.sp = 1;
            end
            default: ;
          endcase
        end else begin
          m_cnt++;
        end
        e.hc = m_pos;
      end
      sb_q.push_back(e);
    end
  end

  // Monitor: compare each registered output once per cycle on the falling edge.
  initial begin
    exp_t e;
    int   prev_sp;
    prev_sp = 0;
    forever begin
      @(negedge clk_in);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        if (!rst_n_in) begin
          e.hc = 0;
          e.sp = 0;
        end
        checkOutput("heart_cnt", int'(heart_cnt), e.hc);
        checkOutput("step_pulse", int'(step_pulse), e.sp);
        checkOutput("pulse_back_to_back", prev_sp & int'(step_pulse), 0);
        checkOutput("pulse_while_blank", int'(step_pulse && heart_cnt == 4'd8), 0);
        checkOutput("heart_range", int'(heart_cnt > 4'd8), 0);
        prev_sp = int'(step_pulse);
      end
    end
  end

  initial begin
    int n;
    rst_n_in = 1'b0;
    en_in    = 1'b0;
    mode_in  = 2'b00;
    repeat (3) @(negedge clk_in);
    checkOutput("reset_heart_cnt", int'(heart_cnt), 0);
    checkOutput("reset_step_pulse", int'(step_pulse), 0);

    rst_n_in = 1'b1;
    applyStimulus(1'b1, 2'b00, 8 * CLK_DIV);
    applyStimulus(1'b1, 2'b01, 8 * CLK_DIV);
    applyStimulus(1'b1, 2'b10, 16 * CLK_DIV);

    en_in   = 1'b1;
    mode_in = 2'b00;
    waitHeart(5);
    applyStimulus(1'b0, 2'b00, 10);
    checkOutput("blank_while_disabled", int'(heart_cnt), 8);
    applyStimulus(1'b1, 2'b00, 1);
    checkOutput("resume_value", int'(heart_cnt), 5);
    applyStimulus(1'b1, 2'b00, CLK_DIV);
    checkOutput("resume_step", int'(heart_cnt), 6);

    applyStimulus(1'b1, 2'b11, 20);
    n = 0;
    while (m_cnt != CLK_DIV - 1 && n < 3 * CLK_DIV) begin
      @(negedge clk_in);
      n++;
    end
    checkOutput("tick_align", m_cnt, CLK_DIV - 1);
    applyStimulus(1'b1, 2'b00, 3 * CLK_DIV);

    waitHeart(6);
    @(negedge clk_in);
    #2 rst_n_in = 1'b0;
    #1;
    checkOutput("async_reset_heart_cnt", int'(heart_cnt), 0);
    checkOutput("async_reset_step_pulse", int'(step_pulse), 0);
    repeat (2) @(negedge clk_in);
    rst_n_in = 1'b1;
    applyStimulus(1'b1, 2'b00, 10 * CLK_DIV);

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 15) == 0) en_in = ~en_in;
      if ($urandom_range(0, 7) == 0) mode_in = 2'($urandom_range(0, 3));
      @(negedge clk_in);
    end

    applyStimulus(1'b1, 2'b10, 4 * CLK_DIV);
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
